eth_gmii_tx_arb: RTL and testbench

Multi-channel GMII transmit MAC: arbitrates CHANNELS AXI-Stream frame sources onto one 8-bit GMII transmit interface and does the framing. Inserts preamble/SFD, pads short frames, appends FCS and enforces inter-frame gap. Generalises the single-source 1G transmit path with channel count, selectable arbitration and frame-abort handling. Sits between per-priority TX queues and the PHY-side GMII output logic.

---
 rtl/eth_tx_pkg.sv | 30 +++
 rtl/eth_tx_rr_arb.sv | 48 ++++
 rtl/eth_gmii_tx_arb.sv | 172 +++++++++++++++++
 tb/tb_eth_gmii_tx_arb.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_tx_pkg.sv
// Shared types, GMII framing constants and the byte-wise CRC-32 step used by the
// multi-channel GMII transmit path.
package eth_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    PAYLOAD,
    PAD,
    FCS,
    IFG,
    DRAIN
  } tx_state_t;

  localparam logic [7:0]  ETH_PRE    = 8'h55;
  localparam logic [7:0]  ETH_SFD    = 8'hD5;
  localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

  // Reflected (LSB-first) CRC-32 over one byte; result is the raw register, not inverted.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] poly_r;
    logic [31:0] c;
    for (int i = 0; i < 32; i++) poly_r[i] = CRC32_POLY[31-i];
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ poly_r) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/eth_tx_rr_arb.sv
// Request/grant arbiter: round-robin from the last grant, or fixed lowest-index priority.
// The pointer only moves when the grant is actually taken (load).
module eth_tx_rr_arb #(
  parameter int CHANNELS = 2,
  parameter int ARB_MODE = 0,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic [CHANNELS-1:0] req,
  input  logic                load,
  output logic [CH_W-1:0]     grant_idx,
  output logic                grant_vld
);

  logic [CH_W-1:0] ptr;

  // Later loop iterations overwrite earlier ones, so the highest-priority hit is visited last.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    if (ARB_MODE == 0) begin
      for (int k = CHANNELS; k >= 1; k--) begin
        if (req[(int'(ptr) + k) % CHANNELS]) begin
          grant_vld = 1'b1;
          grant_idx = CH_W'((int'(ptr) + k) % CHANNELS);
        end
      end
    end else begin
      for (int i = CHANNELS - 1; i >= 0; i--) begin
        if (req[i]) begin
          grant_vld = 1'b1;
          grant_idx = CH_W'(i);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= CH_W'(CHANNELS - 1);
    end else if (ce && load && grant_vld) begin
      ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/eth_gmii_tx_arb.sv
// Multi-channel GMII transmit MAC: arbitrates AXI-Stream sources, adds preamble/SFD,
// pads, appends FCS, enforces inter-frame gap and handles mid-frame underflow.
module eth_gmii_tx_arb
  import eth_tx_pkg::*;
#(
  parameter int CHANNELS         = 2,
  parameter int ENABLE_PADDING   = 1,
  parameter int MIN_FRAME_LENGTH = 64,
  parameter int ARB_MODE         = 0,
  localparam int CH_W            = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CHANNELS*8-1:0] s_axis_tdata,
  input  logic [CHANNELS-1:0]   s_axis_tvalid,
  output logic [CHANNELS-1:0]   s_axis_tready,
  input  logic [CHANNELS-1:0]   s_axis_tlast,
  input  logic [CHANNELS-1:0]   s_axis_tuser,
  output logic [7:0]            gmii_txd,
  output logic                  gmii_tx_en,
  output logic                  gmii_tx_er,
  input  logic                  clk_enable,
  input  logic [7:0]            ifg_delay,
  output logic                  start_packet,
  output logic [CH_W-1:0]       start_channel,
  output logic                  error_underflow
);

  localparam logic [15:0] PAD_LEN = 16'(MIN_FRAME_LENGTH - 4);

  tx_state_t       state;
  logic [CH_W-1:0] gnt;
  logic [2:0]      pre_cnt;
  logic [1:0]      fcs_cnt;
  logic [7:0]      ifg_cnt;
  logic [15:0]     byte_cnt;
  logic [15:0]     byte_next;
  logic [31:0]     crc;
  logic [31:0]     fcs_val;
  logic            bad;
  logic [CH_W-1:0] arb_idx;
  logic            arb_vld;
  logic [7:0]      ch_data;
  logic            ch_valid;
  logic            ch_last;
  logic            ch_user;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  eth_tx_rr_arb #(
    .CHANNELS(CHANNELS),
    .ARB_MODE(ARB_MODE),
    .CH_W    (CH_W)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .ce       (clk_enable),
    .req      (s_axis_tvalid),
    .load     (state == IDLE),
    .grant_idx(arb_idx),
    .grant_vld(arb_vld)
  );

  assign ch_data   = s_axis_tdata[{gnt, 3'b000} +: 8];
  assign ch_valid  = s_axis_tvalid[gnt];
  assign ch_last   = s_axis_tlast[gnt];
  assign ch_user   = s_axis_tuser[gnt];
  assign byte_next = sat_inc(byte_cnt);
  assign fcs_val   = ~crc;

  always_comb begin
    s_axis_tready = '0;
    if (clk_enable && (state == PAYLOAD || state == DRAIN)) s_axis_tready[gnt] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      gnt             <= '0;
      pre_cnt         <= '0;
      fcs_cnt         <= '0;
      ifg_cnt         <= '0;
      byte_cnt        <= '0;
      crc             <= CRC32_INIT;
      bad             <= 1'b0;
      gmii_txd        <= '0;
      gmii_tx_en      <= 1'b0;
      gmii_tx_er      <= 1'b0;
      start_packet    <= 1'b0;
      start_channel   <= '0;
      error_underflow <= 1'b0;
    end else if (clk_enable) begin
      gmii_txd        <= '0;
      gmii_tx_en      <= 1'b0;
      gmii_tx_er      <= 1'b0;
      start_packet    <= 1'b0;
      error_underflow <= 1'b0;
      case (state)
        IDLE: begin
          // The first preamble byte leaves with the grant, so PREAMBLE counts from 1.
          if (arb_vld) begin
            gnt           <= arb_idx;
            start_channel <= arb_idx;
            start_packet  <= 1'b1;
            gmii_tx_en    <= 1'b1;
            gmii_txd      <= ETH_PRE;
            pre_cnt       <= 3'd1;
            fcs_cnt       <= 2'd0;
            byte_cnt      <= '0;
            crc           <= CRC32_INIT;
            bad           <= 1'b0;
            state         <= PREAMBLE;
          end
        end
        PREAMBLE: begin
          gmii_tx_en <= 1'b1;
          gmii_txd   <= (pre_cnt == 3'd7) ? ETH_SFD : ETH_PRE;
          pre_cnt    <= pre_cnt + 3'd1;
          if (pre_cnt == 3'd7) state <= PAYLOAD;
        end
        PAYLOAD: begin
          gmii_tx_en <= 1'b1;
          if (ch_valid) begin
            gmii_txd <= ch_data;
            crc      <= crc32_byte(crc, ch_data);
            byte_cnt <= byte_next;
            if (ch_last) begin
              bad     <= ch_user;
              fcs_cnt <= 2'd0;
              state   <= (ENABLE_PADDING != 0 && byte_next < PAD_LEN) ? PAD : FCS;
            end
          end else begin
            gmii_tx_er      <= 1'b1;
            error_underflow <= 1'b1;
            state           <= DRAIN;
          end
        end
        PAD: begin
          gmii_tx_en <= 1'b1;
          crc        <= crc32_byte(crc, 8'h00);
          byte_cnt   <= byte_next;
          fcs_cnt    <= 2'd0;
          if (byte_next >= PAD_LEN) state <= FCS;
        end
        FCS: begin
          gmii_tx_en <= 1'b1;
          gmii_tx_er <= bad;
          gmii_txd   <= fcs_val[{fcs_cnt, 3'b000} +: 8];
          fcs_cnt    <= fcs_cnt + 2'd1;
          if (fcs_cnt == 2'd3) begin
            ifg_cnt <= ifg_delay;
            state   <= (ifg_delay == 8'd0) ? IDLE : IFG;
          end
        end
        IFG: begin
          ifg_cnt <= ifg_cnt - 8'd1;
          if (ifg_cnt <= 8'd1) state <= IDLE;
        end
        DRAIN: begin
          if (ch_valid && ch_last) begin
            ifg_cnt <= ifg_delay;
            state   <= (ifg_delay == 8'd0) ? IDLE : IFG;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_gmii_tx_arb.sv
// Directed bench for eth_gmii_tx_arb: instance A is 4-channel round-robin with padding,
// instance B is 4-channel fixed priority without padding; both share the stream inputs.
module tb_eth_gmii_tx_arb;

  localparam int CH = 4;

  typedef struct packed {
    logic       hole;
    logic       last;
    logic       user;
    logic [7:0] data;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            clk_enable = 1'b1;
  logic [7:0]      ifg_delay = 8'd12;
  logic [CH*8-1:0] s_axis_tdata = '0;
  logic [CH-1:0]   s_axis_tvalid = '0;
  logic [CH-1:0]   s_axis_tlast = '0;
  logic [CH-1:0]   s_axis_tuser = '0;
  logic [CH-1:0]   tready_a, tready_b;
  logic [7:0]      txd_a, txd_b;
  logic            en_a, en_b, er_a, er_b, sp_a, sp_b, uf_a, uf_b;
  logic [1:0]      sc_a, sc_b;
  logic            sel = 1'b0;

  beat_t      mem [CH][1024];
  int         head [CH];
  int         tail [CH];
  logic [8:0] cap[$];
  logic [8:0] ref_q[$];
  logic [8:0] exp_q[$];
  int         gq[$];
  int         gaps[$];
  int         uf_cnt, idle_run;
  bit         seen;
  int         total, bad;

  always #5 clk = ~clk;

  eth_gmii_tx_arb #(.CHANNELS(4), .ENABLE_PADDING(1), .MIN_FRAME_LENGTH(64), .ARB_MODE(0)) u_dut_a (
    .clk(clk), .rst(rst), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(tready_a), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .gmii_txd(txd_a), .gmii_tx_en(en_a), .gmii_tx_er(er_a), .clk_enable(clk_enable),
    .ifg_delay(ifg_delay), .start_packet(sp_a), .start_channel(sc_a), .error_underflow(uf_a));

  eth_gmii_tx_arb #(.CHANNELS(4), .ENABLE_PADDING(0), .MIN_FRAME_LENGTH(64), .ARB_MODE(1)) u_dut_b (
    .clk(clk), .rst(rst), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(tready_b), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .gmii_txd(txd_b), .gmii_tx_en(en_b), .gmii_tx_er(er_b), .clk_enable(clk_enable),
    .ifg_delay(ifg_delay), .start_packet(sp_b), .start_channel(sc_b), .error_underflow(uf_b));

  wire [CH-1:0] tready = sel ? tready_b : tready_a;
  wire [7:0]    txd    = sel ? txd_b : txd_a;
  wire          en     = sel ? en_b : en_a;
  wire          er     = sel ? er_b : er_a;
  wire          sp     = sel ? sp_b : sp_a;
  wire          uf     = sel ? uf_b : uf_a;
  wire [1:0]    sc     = sel ? sc_b : sc_a;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic bit all_empty();
    for (int c = 0; c < CH; c++) if (head[c] < tail[c]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic add_frame(input int ch, input int len, input logic [7:0] seed, input bit user,
                           input int hole_at);
    for (int i = 0; i < len; i++) begin
      if (i == hole_at) begin
        mem[ch][tail[ch]] = {1'b1, 1'b0, 1'b0, 8'h00};
        tail[ch]++;
      end
      mem[ch][tail[ch]] = {1'b0, (i == len - 1), (user && i == len - 1), seed + 8'(i)};
      tail[ch]++;
    end
  endtask

  task automatic clear_mon();
    cap.delete(); gq.delete(); gaps.delete();
    uf_cnt = 0; idle_run = 0; seen = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int c = 0; c < CH; c++) begin head[c] = 0; tail[c] = 0; end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_mon();
  endtask

  task automatic run(input string tag, input int budget, input bit toggle);
    bit done;
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      @(posedge clk); #1;
      if (toggle) clk_enable = ~clk_enable;
      if (all_empty() && idle_run >= 16) done = 1'b1;
    end
    clk_enable = 1'b1;
    check_eq({tag, "_done"}, done, 1);
  endtask

  task automatic cmp_frame(input string tag, input int len, input logic [7:0] seed, input bit user,
                           input bit pad);
    logic [31:0] c;
    logic [7:0]  b;
    int          n, diffs;
    exp_q.delete();
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, 8'h55});
    exp_q.push_back({1'b0, 8'hD5});
    n = 0;
    for (int i = 0; i < len; i++) begin
      b = seed + 8'(i);
      exp_q.push_back({1'b0, b});
      c = crc_step(c, b);
      n++;
    end
    while (pad && n < 60) begin
      exp_q.push_back(9'h000);
      c = crc_step(c, 8'h00);
      n++;
    end
    c = ~c;
    for (int k = 0; k < 4; k++) exp_q.push_back({user, c[8*k +: 8]});
    check_eq({tag, "_len"}, cap.size(), exp_q.size());
    diffs = 0;
    for (int i = 0; i < exp_q.size(); i++) if (i >= cap.size() || cap[i] !== exp_q[i]) diffs++;
    check_eq({tag, "_bytes"}, diffs, 0);
  endtask

  // Stream sources: handshake seen in mid-cycle, beats advanced just after the edge.
  initial begin
    logic [CH-1:0] xfer;
    forever begin
      @(negedge clk);
      xfer = s_axis_tvalid & tready;
      @(posedge clk); #1;
      for (int c = 0; c < CH; c++) begin
        if (head[c] < tail[c] && (mem[c][head[c]].hole || xfer[c])) head[c]++;
        if (head[c] < tail[c] && !mem[c][head[c]].hole) begin
          s_axis_tvalid[c]          = 1'b1;
          s_axis_tdata[8*c +: 8]    = mem[c][head[c]].data;
          s_axis_tlast[c]           = mem[c][head[c]].last;
          s_axis_tuser[c]           = mem[c][head[c]].user;
        end else begin
          s_axis_tvalid[c] = 1'b0;
          s_axis_tlast[c]  = 1'b0;
          s_axis_tuser[c]  = 1'b0;
        end
      end
    end
  end

  // Output monitor: one record per enabled clock edge.
  initial begin
    logic ce_q;
    ce_q = 1'b0;
    forever begin
      @(negedge clk);
      if (ce_q && !rst) begin
        if (en) begin
          if (seen && idle_run > 0) gaps.push_back(idle_run);
          cap.push_back({er, txd});
          idle_run = 0;
          seen = 1'b1;
        end else begin
          idle_run++;
        end
        if (sp) gq.push_back(int'(sc));
        if (uf) uf_cnt++;
      end
      ce_q = clk_enable;
    end
  end

  initial begin
    int ercnt;
    total = 0; bad = 0;
    for (int c = 0; c < CH; c++) begin head[c] = 0; tail[c] = 0; end
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_txd", txd_a, 0);
    check_eq("rst_ctl", {en_a, er_a, sp_a, uf_a, sc_a}, 0);
    check_eq("rst_tready", tready_a, 0);
    rst = 1'b0;

    // Reset mid-frame: outputs clear without waiting for a clock, no tx_er emitted.
    add_frame(0, 60, 8'h20, 1'b0, -1);
    repeat (30) @(posedge clk);
    @(negedge clk); #1 rst = 1'b1;
    #1;
    check_eq("rst_async_en", en_a, 0);
    check_eq("rst_async_txd", txd_a, 0);
    ercnt = 0;
    foreach (cap[i]) if (cap[i][8]) ercnt++;
    check_eq("rst_no_er", ercnt, 0);

    // Single byte, padded to minimum length.
    do_reset();
    add_frame(0, 1, 8'hAB, 1'b0, -1);
    run("pad", 400, 1'b0);
    cmp_frame("pad", 1, 8'hAB, 1'b0, 1'b1);
    check_eq("pad_grants", gq.size(), 1);
    check_eq("pad_ch", (gq.size() > 0) ? gq[0] : -1, 0);

    // "123456789" on ch1 without padding.
    sel = 1'b1;
    do_reset();
    add_frame(1, 9, 8'h31, 1'b0, -1);
    run("crc", 400, 1'b0);
    check_eq("crc_len", cap.size(), 21);
    if (cap.size() == 21) begin
      check_eq("crc_b0", cap[17], 9'h026);
      check_eq("crc_b1", cap[18], 9'h039);
      check_eq("crc_b2", cap[19], 9'h0F4);
      check_eq("crc_b3", cap[20], 9'h0CB);
    end
    cmp_frame("crc", 9, 8'h31, 1'b0, 1'b0);
    check_eq("crc_ch", (gq.size() > 0) ? gq[0] : -1, 1);

    // Fixed priority: ch2 keeps winning while valid, then ch3.
    do_reset();
    add_frame(2, 4, 8'h60, 1'b0, -1);
    add_frame(2, 4, 8'h70, 1'b0, -1);
    add_frame(3, 4, 8'h80, 1'b0, -1);
    run("fix", 600, 1'b0);
    check_eq("fix_grants", gq.size(), 3);
    if (gq.size() == 3) begin
      check_eq("fix_g0", gq[0], 2);
      check_eq("fix_g1", gq[1], 2);
      check_eq("fix_g2", gq[2], 3);
    end

    // Round-robin over four continuously valid channels, 64-byte frames.
    sel = 1'b0;
    do_reset();
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < CH; c++) add_frame(c, 60, 8'(16 * c + k), 1'b0, -1);
    run("rr", 2000, 1'b0);
    check_eq("rr_grants", gq.size(), 8);
    for (int i = 0; i < 5 && i < gq.size(); i++) check_eq($sformatf("rr_g%0d", i), gq[i], i % 4);
    check_eq("rr_ngaps", gaps.size(), 7);
    foreach (gaps[i]) check_eq($sformatf("rr_gap%0d", i), gaps[i], 12);
    check_eq("rr_bytes", cap.size(), 8 * 72);

    // Underflow after the 10th byte.
    do_reset();
    add_frame(0, 15, 8'h10, 1'b0, 10);
    run("uf", 400, 1'b0);
    check_eq("uf_len", cap.size(), 19);
    if (cap.size() == 19) begin
      check_eq("uf_last_data", cap[17], 9'h019);
      check_eq("uf_err_byte", cap[18], 9'h100);
    end
    check_eq("uf_pulses", uf_cnt, 1);

    // Bad frame: FCS sent with tx_er; same bytes with clk_enable toggling.
    do_reset();
    add_frame(0, 3, 8'h40, 1'b1, -1);
    run("bad", 400, 1'b0);
    cmp_frame("bad", 3, 8'h40, 1'b1, 1'b1);
    ercnt = 0;
    foreach (cap[i]) if (cap[i][8]) ercnt++;
    check_eq("bad_er_cnt", ercnt, 4);
    ref_q = cap;
    do_reset();
    add_frame(0, 3, 8'h40, 1'b1, -1);
    run("ce", 800, 1'b1);
    check_eq("ce_len", cap.size(), ref_q.size());
    ercnt = 0;
    foreach (ref_q[i]) if (i >= cap.size() || cap[i] !== ref_q[i]) ercnt++;
    check_eq("ce_seq", ercnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
